// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory block: loader state encoding,
// default boot base address and the CPU opcodes used to assemble programs.
package program_memory_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // First word written by the boot loader; also the CPU start PC.
  localparam int BOOT_BASE_DEFAULT = 8;

  // CPU opcodes (top nibble of an instruction word).
  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_IN  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;

  // Build a 16-bit instruction word from opcode and operand field.
  function automatic logic [15:0] asm_word(input logic [3:0] op, input logic [11:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/program_memory_ram_sync.sv
// Single-port synchronous RAM: registered read, read-before-write on a
// same-address write, read register cleared by reset and held when re=0.
module ram_sync #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array write port.
  // NOTE: the storage array is deliberately left without reset so it maps onto
  // RAM macros; only the read register below is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port.
  // NOTE: non-blocking assignments mean this samples mem[addr] before the write
  // above lands, which is exactly the read-before-write behaviour we want.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/program_memory.sv
// Program memory: boot loader streams a program into RAM from BOOT_BASE up,
// then releases the CPU from reset and hands the RAM port to the CPU.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int BOOT_BASE  = BOOT_BASE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  boot_valid,
  input  logic [DATA_WIDTH-1:0] boot_data,
  input  logic                  boot_last,
  output logic                  boot_ready,
  output logic                  cpu_rst_n,
  output logic                  loaded
);

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BOOT_BASE);
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] load_addr_q;
  logic                  xfer;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  // Next state, handshake and RAM port mux between loader and CPU.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    boot_ready = 1'b0;
    loaded     = 1'b0;
    xfer       = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = addr;
    ram_wdata  = data;
    case (state_q)
      ST_LOAD: begin
        boot_ready = 1'b1;
        xfer       = boot_valid;
        ram_we     = boot_valid;
        ram_addr   = load_addr_q;
        ram_wdata  = boot_data;
        // The top word ends the load: no wrap into the low addresses.
        if (boot_valid && (boot_last || load_addr_q == TOP_ADDR)) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        loaded = 1'b1;
        ram_we = we;
        ram_re = 1'b1;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State register and CPU reset flop; cpu_rst_n rises together with RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      cpu_rst_n <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_rst_n <= (state_d == ST_RUN);
    end
  end

  // Boot write pointer, advanced on every accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_addr_q <= BASE_ADDR;
    end else if (xfer) begin
      load_addr_q <= load_addr_q + 1'b1;
    end
  end

  ram_sync #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(out)
  );

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: directed boot/run sequences, a
// vector table for CPU read/write timing, and randomized traffic against an
// array-based reference model.
module tb_program_memory;
  import program_memory_pkg::*;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int BASE  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [DW-1:0] out;
  logic          boot_valid;
  logic [DW-1:0] boot_data;
  logic          boot_last;
  logic          boot_ready;
  logic          cpu_rst_n;
  logic          loaded;

  always #5 clk = ~clk;

  program_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BOOT_BASE(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .addr      (addr),
    .data      (data),
    .out       (out),
    .boot_valid(boot_valid),
    .boot_data (boot_data),
    .boot_last (boot_last),
    .boot_ready(boot_ready),
    .cpu_rst_n (cpu_rst_n),
    .loaded    (loaded)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, which words are defined, and phase
  // (0 = loading, 1 = release cycle, 2 = CPU running).
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  int            m_phase;
  int            m_ptr;
  logic [DW-1:0] m_out;
  bit            m_out_known;
  int            xfers;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase     = 0;
    m_ptr       = BASE;
    m_out       = '0;
    m_out_known = 1'b1;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    case (m_phase)
      0: if (boot_valid) begin
        xfers++;
        m_mem[m_ptr]   = boot_data;
        m_known[m_ptr] = 1'b1;
        if (boot_last || m_ptr == DEPTH - 1) m_phase = 1;
        m_ptr++;
      end
      1: m_phase = 2;
      default: begin
        m_out       = m_mem[addr];
        m_out_known = m_known[addr];
        if (we) begin
          m_mem[addr]   = data;
          m_known[addr] = 1'b1;
        end
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".boot_ready"}, {31'd0, boot_ready}, {31'd0, m_phase == 0});
    check({tag, ".cpu_rst_n"},  {31'd0, cpu_rst_n},  {31'd0, m_phase == 2});
    check({tag, ".loaded"},     {31'd0, loaded},     {31'd0, m_phase == 2});
    if (m_out_known) check({tag, ".out"}, {16'd0, out}, {16'd0, m_out});
  endtask

  // One clock: model steps, DUT steps, compare 1 time unit after the edge.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("reset_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs("reset");
  endtask

  task automatic boot(input logic [DW-1:0] d, input logic l);
    boot_valid = 1'b1;
    boot_data  = d;
    boot_last  = l;
    cycle("boot");
    boot_valid = 1'b0;
    boot_last  = 1'b0;
  endtask

  task automatic cpu(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we   = w;
    addr = a;
    data = d;
    cycle("cpu");
    we   = 1'b0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] gap_data [5];
    logic          gap_valid[5];
    logic          gap_last [5];

    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    xfers      = 0;
    rst_n      = 1'b0;
    we         = 1'b0;
    addr       = '0;
    data       = '0;
    boot_valid = 1'b0;
    boot_data  = '0;
    boot_last  = 1'b0;
    model_reset();

    vt[0] = '{1'b0, 6'd8,  16'h0000, 1'b1, 16'h7100};
    vt[1] = '{1'b0, 6'd9,  16'h0000, 1'b1, 16'h8100};
    vt[2] = '{1'b0, 6'd10, 16'h0000, 1'b1, 16'h0000};
    vt[3] = '{1'b1, 6'd2,  16'h1234, 1'b0, 16'h0000};
    vt[4] = '{1'b0, 6'd2,  16'h0000, 1'b1, 16'h1234};
    vt[5] = '{1'b1, 6'd3,  16'hAAAA, 1'b0, 16'h0000};
    vt[6] = '{1'b1, 6'd3,  16'h5555, 1'b1, 16'hAAAA};
    vt[7] = '{1'b0, 6'd3,  16'h0000, 1'b1, 16'h5555};
    vt[8] = '{1'b1, 6'd1,  16'h0BEE, 1'b0, 16'h0000};
    vt[9] = '{1'b0, 6'd1,  16'h0000, 1'b1, 16'h0BEE};

    // Three-word boot, valid every cycle, then CPU release timing.
    apply_reset();
    check("reset_out", {16'd0, out}, 32'd0);
    boot(asm_word(OP_IN, 12'h100), 1'b0);
    boot(asm_word(OP_OUT, 12'h100), 1'b0);
    boot(asm_word(OP_MOV, 12'h000), 1'b1);
    check("release_edge_n.cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("release_edge_n.boot_ready", {31'd0, boot_ready}, 32'd0);
    cycle("release");
    check("release_edge_n1.cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    check("release_edge_n1.loaded", {31'd0, loaded}, 32'd1);

    // CPU timing vectors: readback of boot words, write-then-read, RBW.
    for (int i = 0; i < 10; i++) begin
      we   = vt[i].we;
      addr = vt[i].addr;
      data = vt[i].data;
      cycle("vec");
      if (vt[i].chk) check($sformatf("vec%0d.out", i), {16'd0, out}, {16'd0, vt[i].exp});
    end
    we = 1'b0;
    for (int i = 0; i < BASE; i++) cpu(1'b1, AW'(i), DW'(16'h1111 * (i + 1)));

    // Reload with gaps; CPU port hammers addr 1 throughout LOAD/RELEASE.
    apply_reset();
    we   = 1'b1;
    addr = 6'd1;
    data = 16'hFFFF;
    gap_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    gap_last  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    gap_data  = '{16'h0011, 16'hDEAD, 16'hDEAD, 16'h0022, 16'h0033};
    n = xfers;
    for (int i = 0; i < 5; i++) begin
      boot_valid = gap_valid[i];
      boot_last  = gap_last[i];
      boot_data  = gap_data[i];
      cycle("gap");
      check("gap.out_zero", {16'd0, out}, 32'd0);
    end
    boot_valid = 1'b0;
    boot_last  = 1'b0;
    check("gap.xfers", xfers - n, 32'd3);
    cycle("gap_release");
    we = 1'b0;
    cpu(1'b0, 6'd1, 16'h0);
    check("load_ignores_cpu.mem1", {16'd0, out}, 32'h2222);
    cpu(1'b0, 6'd8, 16'h0);
    check("gap.mem8", {16'd0, out}, 32'h0011);
    cpu(1'b0, 6'd9, 16'h0);
    check("gap.mem9", {16'd0, out}, 32'h0022);
    cpu(1'b0, 6'd10, 16'h0);
    check("gap.mem10", {16'd0, out}, 32'h0033);

    // Fill to the top without boot_last: stops after address 63.
    apply_reset();
    boot_valid = 1'b1;
    boot_last  = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!boot_ready) break;
      boot_data = DW'($urandom);
      n++;
      cycle("fill");
    end
    check("fill.count", n, 32'd56);
    boot_data = DW'($urandom);
    cycle("fill_release");
    for (int i = 0; i < DEPTH; i++) begin
      boot_data = DW'($urandom);
      boot_last = 1'($urandom);
      cpu(1'b0, AW'(i), 16'h0);
      if (i < BASE) check($sformatf("fill.low%0d", i), {16'd0, out}, 16'h1111 * (i + 1));
    end

    // Randomized CPU traffic with stray boot activity.
    for (int i = 0; i < 400; i++) begin
      boot_valid = 1'($urandom);
      boot_data  = DW'($urandom);
      boot_last  = 1'($urandom);
      we   = 1'($urandom);
      addr = AW'($urandom);
      data = DW'($urandom);
      cycle("rand");
    end
    we         = 1'b0;
    boot_valid = 1'b0;
    boot_last  = 1'b0;

    // Asynchronous reset in RUN clears out immediately.
    cpu(1'b1, 6'd5, 16'hBEEF);
    cpu(1'b0, 6'd5, 16'h0);
    check("pre_reset.out", {16'd0, out}, 32'hBEEF);
    rst_n = 1'b0;
    #1;
    check("async_reset.out", {16'd0, out}, 32'd0);
    check("async_reset.boot_ready", {31'd0, boot_ready}, 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs("async_reset_release");

    // Reset mid-load after two words, then a one-word reload.
    boot(16'hA001, 1'b0);
    boot(16'hA002, 1'b0);
    apply_reset();
    boot(16'hB001, 1'b1);
    cycle("reload_release");
    check("reload.cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    cpu(1'b0, 6'd8, 16'h0);
    check("reload.mem8", {16'd0, out}, 32'hB001);
    cpu(1'b0, 6'd9, 16'h0);
    check("reload.mem9", {16'd0, out}, 32'hA002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
